oam_dma_ctrl: RTL

Sequences the Game Boy OAM DMA and arbitrates the shared system bus between the CPU and the DMA engine. A CPU write to FF46 starts a 160-byte copy from `{src,8'h00}` to FE00–FE9F. During the copy the DMA owns the bus, and CPU bus accesses are blocked. Sits between the CPU bus port and the address/data/strobe lines that fan out to WRAM, cartridge, PPU/OAM and MMIO decode.

---
 rtl/oam_dma_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer and CPU/DMA bus arbiter: FF46 write copies {src,00}..+159 to FE00-FE9F.
// Latency: START 1 cycle, then 160 READ/WRITE pairs; optional restart via OAM_DMA_RESTART_EN.
module oam_dma_ctrl #(
  parameter int OAM_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_din,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  output logic        bus_wr,
  output logic        bus_rd,
  input  logic [7:0]  bus_din,
  output logic        dma_active
);

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  state_t     state;
  logic [7:0] src_hi;
  logic [7:0] idx;
  logic [7:0] data_q;
  logic [7:0] eff_src;
  logic       ff46_sel;
  logic       ff46_wr;
  logic       hram_sel;
  logic       restart;

  assign ff46_sel = (cpu_a == 16'hFF46);
  assign ff46_wr  = cpu_wr && ff46_sel;
  assign hram_sel = (cpu_a >= 16'hFF80) && (cpu_a <= 16'hFFFE);
  // E0-FF sources alias the WRAM echo back onto C0-DF
  assign eff_src  = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;

`ifdef OAM_DMA_RESTART_EN
  assign restart = ff46_wr;
`else
  assign restart = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      src_hi     <= '0;
      data_q     <= '0;
      dma_active <= 1'b0;
    end else begin
      case (state)
        IDLE, START: begin
          if (ff46_wr) begin
            src_hi <= cpu_dout;
            state  <= START;
          end else if (state == START) begin
            idx        <= '0;
            state      <= READ;
            dma_active <= 1'b1;
          end
        end
        READ: begin
          if (restart) begin
            src_hi     <= cpu_dout;
            idx        <= '0;
            state      <= START;
            dma_active <= 1'b0;
          end else begin
            data_q <= bus_din;
            state  <= WRITE;
          end
        end
        WRITE: begin
          // restart beats the end-of-transfer return to IDLE
          if (restart) begin
            src_hi     <= cpu_dout;
            idx        <= '0;
            state      <= START;
            dma_active <= 1'b0;
          end else if (idx == LAST_IDX) begin
            state      <= IDLE;
            dma_active <= 1'b0;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: begin
          state      <= IDLE;
          dma_active <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus_a    = cpu_a;
    bus_dout = cpu_dout;
    bus_wr   = cpu_wr && !ff46_sel;
    bus_rd   = cpu_rd;
    cpu_din  = ff46_sel ? src_hi : bus_din;
    case (state)
      READ: begin
        bus_a    = {eff_src, idx};
        bus_dout = data_q;
        bus_wr   = 1'b0;
        bus_rd   = 1'b1;
        cpu_din  = hram_sel ? bus_din : 8'hFF;
      end
      WRITE: begin
        bus_a    = {8'hFE, idx};
        bus_dout = data_q;
        bus_wr   = 1'b1;
        bus_rd   = 1'b0;
        cpu_din  = hram_sel ? bus_din : 8'hFF;
      end
      default: ;
    endcase
  end

endmodule
